hazard_controller: RTL

- Pipeline sequencing controller for the five-stage ARM core; sits beside the EX stage datapath.
- Generates the forwarding selects for the EX ALU source muxes and detects load-use hazards.
- Flushes IF/ID on taken branches and freezes the whole pipeline while the memory stage waits on SRAM.
- Keeps a watchdog on memory waits and saturating performance counters for stalls, flushes and wait cycles.

---
 rtl/hazard_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: EX-stage forwarding selects, load-use stalls,
// branch flushes, memory-wait freeze with watchdog, and saturating perf counters.
module hazard_controller #(
  parameter int REG_ADDRESS_LEN = 4,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_WAIT        = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       forward_en,
  input  logic [REG_ADDRESS_LEN-1:0] id_src1,
  input  logic [REG_ADDRESS_LEN-1:0] id_src2,
  input  logic                       id_two_src,
  input  logic [REG_ADDRESS_LEN-1:0] ex_src1,
  input  logic [REG_ADDRESS_LEN-1:0] ex_src2,
  input  logic [REG_ADDRESS_LEN-1:0] ex_dest,
  input  logic                       ex_wb_en,
  input  logic                       ex_mem_r_en,
  input  logic                       branch_taken,
  input  logic [REG_ADDRESS_LEN-1:0] mem_dest,
  input  logic                       mem_wb_en,
  input  logic                       mem_access,
  input  logic                       mem_ready,
  input  logic [REG_ADDRESS_LEN-1:0] wb_dest,
  input  logic                       wb_wb_en,
  output logic [1:0]                 alu_mux_sel_src1,
  output logic [1:0]                 alu_mux_sel_src2,
  output logic                       freeze_front,
  output logic                       bubble_ex,
  output logic                       flush_front,
  output logic                       freeze_all,
  output logic                       mem_timeout,
  output logic [CNT_WIDTH-1:0]       stall_count,
  output logic [CNT_WIDTH-1:0]       flush_count,
  output logic [CNT_WIDTH-1:0]       wait_count
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t         state_r, state_next_s;
  logic [WCW-1:0] wait_cnt_r, wait_cnt_next_s;
  logic           mem_timeout_r, mem_timeout_next_s;
  logic           match_ex_s, match_mem_s, hazard_s, wait_req_s, freeze_all_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  // MEM result is newer than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDRESS_LEN-1:0] src,
                                         input logic fwd, input logic m_en,
                                         input logic [REG_ADDRESS_LEN-1:0] m_dest,
                                         input logic w_en,
                                         input logic [REG_ADDRESS_LEN-1:0] w_dest);
    if (fwd && m_en && (m_dest == src)) begin
      fwd_sel = 2'b01;
    end else if (fwd && w_en && (w_dest == src)) begin
      fwd_sel = 2'b10;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  assign match_ex_s  = ex_wb_en & ((id_src1 == ex_dest) | (id_two_src & (id_src2 == ex_dest)));
  assign match_mem_s = mem_wb_en & ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
  assign hazard_s    = forward_en ? (match_ex_s & ex_mem_r_en) : (match_ex_s | match_mem_s);
  assign wait_req_s  = mem_access & ~mem_ready;
  assign freeze_all_s = wait_req_s | (state_r == ST_ERROR);
  assign mem_timeout = mem_timeout_r;

  // ALU source forwarding selects
  always_comb begin
    alu_mux_sel_src1 = 2'b00;
    alu_mux_sel_src2 = 2'b00;
    if (!rst) begin
      alu_mux_sel_src1 = 2'b00;
      alu_mux_sel_src2 = 2'b00;
    end else begin
      alu_mux_sel_src1 = fwd_sel(ex_src1, forward_en, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
      alu_mux_sel_src2 = fwd_sel(ex_src2, forward_en, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    end
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WCW{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wait_cnt_r    <= wait_cnt_next_s;
      mem_timeout_r <= mem_timeout_next_s;
    end
  end

  // Next-state logic for the memory-wait watchdog
  always_comb begin
    state_next_s       = state_r;
    wait_cnt_next_s    = wait_cnt_r;
    mem_timeout_next_s = mem_timeout_r;
    case (state_r)
      ST_RUN: begin
        if (wait_req_s) begin
          state_next_s    = ST_WAIT;
          wait_cnt_next_s = {{(WCW-1){1'b0}}, 1'b1};
        end else begin
          wait_cnt_next_s = {WCW{1'b0}};
        end
      end
      ST_WAIT: begin
        if (!wait_req_s) begin
          state_next_s    = ST_RUN;
          wait_cnt_next_s = {WCW{1'b0}};
        end else if (wait_cnt_r == MAX_WAIT_C) begin
          state_next_s       = ST_ERROR;
          mem_timeout_next_s = 1'b1;
        end else begin
          wait_cnt_next_s = wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end
      end
      ST_ERROR: begin
        state_next_s       = ST_ERROR;
        mem_timeout_next_s = 1'b1;
      end
      default: begin
        state_next_s    = ST_RUN;
        wait_cnt_next_s = {WCW{1'b0}};
      end
    endcase
  end

  // Pipeline control outputs, priority freeze > flush > stall
  always_comb begin
    freeze_front = 1'b0;
    bubble_ex    = 1'b0;
    flush_front  = 1'b0;
    freeze_all   = 1'b0;
    if (!rst) begin
      freeze_all = 1'b0;
    end else if (freeze_all_s) begin
      freeze_all = 1'b1;
    end else if (branch_taken) begin
      flush_front = 1'b1;
      bubble_ex   = 1'b1;
    end else if (hazard_s) begin
      freeze_front = 1'b1;
      bubble_ex    = 1'b1;
    end else begin
      freeze_all = 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= {CNT_WIDTH{1'b0}};
      flush_count <= {CNT_WIDTH{1'b0}};
      wait_count  <= {CNT_WIDTH{1'b0}};
    end else begin
      stall_count <= sat_inc(stall_count, freeze_front);
      flush_count <= sat_inc(flush_count, flush_front);
      wait_count  <= sat_inc(wait_count, wait_req_s & (state_r != ST_ERROR));
    end
  end

endmodule
